// File: rtl/alarm_controller.sv
// Alarm time store/edit plus ring/snooze/timeout sequencer driven by the BCD time-of-day bus.
// Latency: button edge or trigger sampled at a posedge, visible on outputs the next cycle.
// Backpressure: none; every input is consumed every clock and buttons act on rising edges.
module alarm_controller #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sec_tick,
    input  logic [19:0] time_bcd,
    input  logic        set_mode,
    input  logic        alarm_en,
    input  logic        btn_min_up,
    input  logic        btn_min_dn,
    input  logic        btn_hr_up,
    input  logic        btn_hr_dn,
    input  logic        btn_snooze,
    input  logic        btn_stop,
    output logic [12:0] alarm_bcd,
    output logic        ringing,
    output logic        buzzer,
    output logic        led
);

    localparam int unsigned CNT_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int          CW      = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
    } hhmm_t;

    typedef struct packed {
        hhmm_t      hm;
        logic [2:0] st;
        logic [3:0] su;
    } hhmmss_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    hhmmss_t       now_t;
    hhmm_t         alarm_q;
    hhmm_t         alarm_nxt;
    logic [5:0]    btn_q;
    logic [5:0]    btn_now;
    logic [5:0]    btn_edge;
    logic          match;
    logic          match_q;
    logic          trigger;

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          buzzer_q;
    logic          buzzer_nxt;

    logic min_up_e, min_dn_e, hr_up_e, hr_dn_e, snooze_e, stop_e;

    assign now_t    = time_bcd;
    assign btn_now  = {btn_min_up, btn_min_dn, btn_hr_up, btn_hr_dn, btn_snooze, btn_stop};
    assign btn_edge = btn_now & ~btn_q;
    assign {min_up_e, min_dn_e, hr_up_e, hr_dn_e, snooze_e, stop_e} = btn_edge;

    assign match   = (now_t.hm == alarm_q) && (now_t.st == 3'd0) && (now_t.su == 4'd0);
    assign trigger = match & ~match_q & alarm_en & ~set_mode;

    // Digit-wise BCD edit keeps every digit legal; opposing edges on one field cancel.
    always_comb begin
        alarm_nxt = alarm_q;
        if (set_mode) begin
            if (min_up_e && !min_dn_e) begin
                if (alarm_q.mu == 4'd9) begin
                    alarm_nxt.mu = 4'd0;
                    alarm_nxt.mt = (alarm_q.mt == 3'd5) ? 3'd0 : alarm_q.mt + 3'd1;
                end else begin
                    alarm_nxt.mu = alarm_q.mu + 4'd1;
                end
            end else if (min_dn_e && !min_up_e) begin
                if (alarm_q.mu == 4'd0) begin
                    alarm_nxt.mu = 4'd9;
                    alarm_nxt.mt = (alarm_q.mt == 3'd0) ? 3'd5 : alarm_q.mt - 3'd1;
                end else begin
                    alarm_nxt.mu = alarm_q.mu - 4'd1;
                end
            end

            if (hr_up_e && !hr_dn_e) begin
                if (alarm_q.ht == 2'd2 && alarm_q.hu == 4'd3) begin
                    alarm_nxt.ht = 2'd0;
                    alarm_nxt.hu = 4'd0;
                end else if (alarm_q.hu == 4'd9) begin
                    alarm_nxt.ht = alarm_q.ht + 2'd1;
                    alarm_nxt.hu = 4'd0;
                end else begin
                    alarm_nxt.hu = alarm_q.hu + 4'd1;
                end
            end else if (hr_dn_e && !hr_up_e) begin
                if (alarm_q.ht == 2'd0 && alarm_q.hu == 4'd0) begin
                    alarm_nxt.ht = 2'd2;
                    alarm_nxt.hu = 4'd3;
                end else if (alarm_q.hu == 4'd0) begin
                    alarm_nxt.ht = alarm_q.ht - 2'd1;
                    alarm_nxt.hu = 4'd9;
                end else begin
                    alarm_nxt.hu = alarm_q.hu - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q <= '0;
            btn_q   <= '0;
            match_q <= 1'b0;
        end else begin
            alarm_q <= alarm_nxt;
            btn_q   <= btn_now;
            match_q <= match;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            buzzer_q <= buzzer_nxt;
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    // Disarm and stop override everything; snooze outranks the second counter.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        buzzer_nxt = buzzer_q;
        if (set_mode || !alarm_en || stop_e) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            buzzer_nxt = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_nxt    = '0;
                    buzzer_nxt = 1'b0;
                    if (trigger) begin
                        state_nxt  = ST_RINGING;
                        buzzer_nxt = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (snooze_e) begin
                        state_nxt  = ST_SNOOZE;
                        cnt_nxt    = '0;
                        buzzer_nxt = 1'b0;
                    end else if (sec_tick) begin
                        if (cnt_inc == CW'(RING_SECONDS)) begin
                            state_nxt  = ST_IDLE;
                            cnt_nxt    = '0;
                            buzzer_nxt = 1'b0;
                        end else begin
                            cnt_nxt    = cnt_inc;
                            buzzer_nxt = ~buzzer_q;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (sec_tick) begin
                        if (cnt_inc == CW'(SNOOZE_SECONDS)) begin
                            state_nxt  = ST_RINGING;
                            cnt_nxt    = '0;
                            buzzer_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = '0;
                    buzzer_nxt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ringing = (state_q == ST_RINGING);
        led     = (state_q == ST_RINGING) || (state_q == ST_SNOOZE);
    end

    assign buzzer    = buzzer_q;
    assign alarm_bcd = alarm_q;

endmodule
